// File: rtl/bit_serial_alu_ctrl_pkg.sv
// rtl/bit_serial_alu_ctrl_pkg.sv - op codes and state encoding for the bit-serial ALU sequencer
package bit_serial_alu_ctrl_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_1bit.sv
// rtl/alu_1bit.sv - one-bit ALU slice: add, subtract (a + ~b + carry), and, or
module alu_1bit
    import bit_serial_alu_ctrl_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       carry_in,
    input  logic [1:0] op,
    output logic       result_bit,
    output logic       carry_out
);

    logic b_eff;

    always_comb begin
        b_eff      = b;
        result_bit = 1'b0;
        carry_out  = 1'b0;
        case (op)
            OP_ADD, OP_SUB: begin
                // Subtraction reuses the adder with b inverted; the sequencer seeds carry_in = 1
                b_eff      = (op == OP_SUB) ? ~b : b;
                result_bit = a ^ b_eff ^ carry_in;
                carry_out  = (a & b_eff) | (a & carry_in) | (b_eff & carry_in);
            end
            OP_AND:  result_bit = a & b;
            OP_OR:   result_bit = a | b;
            default: result_bit = 1'b0;
        endcase
    end

endmodule

// File: rtl/bit_serial_alu_ctrl.sv
// rtl/bit_serial_alu_ctrl.sv - sequences WIDTH-bit ops through one alu_1bit slice, LSB first
module bit_serial_alu_ctrl
    import bit_serial_alu_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op_code,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             zero
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [1:0]       op_reg;
    logic [CNT_W-1:0] cnt;
    logic             carry_reg;
    logic             slice_res;
    logic             slice_carry;
    logic [WIDTH-1:0] shifted;

    alu_1bit u_slice (
        .a          (a_reg[cnt]),
        .b          (b_reg[cnt]),
        .carry_in   (carry_reg),
        .op         (op_reg),
        .result_bit (slice_res),
        .carry_out  (slice_carry)
    );

    // After WIDTH shifts the first (LSB) result bit has reached position 0
    assign shifted = {slice_res, result[WIDTH-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            op_reg    <= OP_ADD;
            cnt       <= '0;
            carry_reg <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            zero      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg     <= a;
                        b_reg     <= b;
                        op_reg    <= op_code;
                        cnt       <= '0;
                        carry_reg <= (op_code == OP_SUB);
                        busy      <= 1'b1;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    result    <= shifted;
                    carry_reg <= slice_carry;
                    if (cnt == LAST) begin
                        state     <= DONE;
                        done      <= 1'b1;
                        carry_out <= slice_carry;
                        zero      <= (shifted == '0);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/bit_serial_alu_ctrl.md
Name: bit_serial_alu_ctrl

Overview:
- Sequencer that runs WIDTH-bit ADD/SUB/AND/OR operations through a single alu_1bit slice, one bit per clock, LSB first.
- Holds the inter-bit carry in a flop and shifts result bits into a register.
- Reports completion with a one-cycle done pulse plus carry and zero flags.
- Gives the one-bit ALU slice a multi-bit host interface for small controllers in the design.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range WIDTH >= 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- op_code  input  2  00 ADD, 01 SUB (a - b), 10 AND, 11 OR; sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse; result and flags are valid.
- result  output  WIDTH  operation result; held until the next accepted start.
- carry_out  output  1  final carry. ADD: carry out of the MSB. SUB: 1 means no borrow. AND/OR: 0.
- zero  output  1  result == 0; updated together with done.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state = IDLE, busy = 0, done = 0, result = 0, carry_out = 0, zero = 0. All internal operand, op, count and carry registers are cleared.
- State IDLE:
  - If start = 1 at edge E0: latch a, b and op_code into internal registers.
  - Set bit counter to 0.
  - Set carry register to 1 if op_code == 01, else 0.
  - Go to RUN.
  - If start = 0: stay in IDLE.
- State RUN, at each edge:
  - Drive the slice with a_reg[cnt], b_reg[cnt], the carry register and op_reg.
  - Shift result right by one, inserting the slice's result_bit at the MSB.
  - Load the carry register from the slice's carry_out.
  - Increment cnt.
  - At the edge where cnt == WIDTH-1 (edge E_WIDTH), go to DONE. On the same edge, load carry_out from the slice carry and set zero from the final shifted value.
- State DONE:
  - done = 1 for exactly this cycle.
  - Next edge returns to IDLE and clears done.
- Latency: start sampled at E0 -> done high in the cycle after E_WIDTH, which is WIDTH+1 cycles of busy in total.
- Width rules:
  - cnt is $clog2(WIDTH) bits and never exceeds WIDTH-1; there is no wrap in normal operation.
  - result is always exactly WIDTH bits. Arithmetic overflow is signalled only through carry_out.
- Busy handling:
  - start while busy, including in DONE, is ignored; no queueing.
  - a, b and op_code changes while busy have no effect.
- Back-to-back operation: start may be accepted in the first IDLE cycle after DONE, i.e. a minimum of WIDTH+2 cycles between accepted starts.
- Output stability: result, carry_out and zero change only during RUN/DONE updates. During RUN, result holds partially shifted data and is not valid until done.
- Reset mid-operation: asserting rst in any state immediately forces reset values. No done pulse is produced for the aborted operation.

Decomposition:
- Shared package holds:
  - Op codes: OP_ADD = 2'b00, OP_SUB = 2'b01, OP_AND = 2'b10, OP_OR = 2'b11.
  - State encoding typedef: IDLE, RUN, DONE.
- Sub-module: exactly one instance of the existing alu_1bit slice. The controller contains only FSM, counter, shift/operand registers and the carry flop.

Test Plan:
- ADD a=8'h3C, b=8'h05 -> done 9 cycles after the start edge, result=8'h41, carry_out=0, zero=0; busy high for exactly 9 cycles.
- ADD a=8'hFF, b=8'h01 -> result=8'h00, carry_out=1, zero=1.
- SUB 8'h05-8'h03 -> result=8'h02, carry_out=1. SUB 8'h03-8'h05 -> result=8'hFE, carry_out=0.
- AND 8'hF0 & 8'h3C -> 8'h30, carry_out=0. OR 8'hF0 | 8'h0C -> 8'hFC, carry_out=0.
- start pulsed again at cycle 3 of a run, with a/b/op_code changed mid-run -> first result unaffected, only one done. Then start in the first IDLE cycle -> accepted.
- rst asserted asynchronously at cycle 4 of a run -> all outputs 0 immediately, no done. Next start after reset release completes correctly.
